// File: rtl/router_lookup_pkg.sv
// Shared definitions for the checksum engine arbiter.
//   arb_state_e : arbiter FSM state encoding
//   FoldW       : width of the folded checksum result
//   ErrResult   : result reported when a transaction times out
//   fold_sum()  : end-around-carry fold of a 32-bit raw sum, complemented
package router_lookup_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StWait    = 2'd2,
        StDeliver = 2'd3
    } arb_state_e;

    localparam int unsigned FoldW = 16;

    localparam logic [FoldW-1:0] ErrResult = 16'hFFFF;

    // Two halves are added, the carry out is wrapped back in once, and the
    // result is complemented. The second add cannot carry again.
    function automatic logic [FoldW-1:0] fold_sum(input logic [2*FoldW-1:0] sum);
        logic [FoldW:0]   s1;
        logic [FoldW-1:0] s2;
        s1 = {1'b0, sum[FoldW-1:0]} + {1'b0, sum[2*FoldW-1:FoldW]};
        s2 = s1[FoldW-1:0] + {{(FoldW-1){1'b0}}, s1[FoldW]};
        return ~s2;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker.
//   req      : request vector, one bit per requester
//   last_idx : index of the requester served most recently
//   pick     : one-hot winner, the first set req bit searching upward from
//              (last_idx + 1) mod NUM_REQ; all-zero when req is all-zero
module rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_idx,
    output logic [NUM_REQ-1:0]         pick
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    logic            found;
    logic [IdxW-1:0] idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        // Offset 1 checks the requester just after the last winner; offset
        // NUM_REQ wraps round to the last winner itself, so it is lowest.
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = IdxW'((32'(last_idx) + off) % NUM_REQ);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/checksum_engine_arbiter.sv
// Round-robin arbiter sharing one checksum engine among NUM_REQ requesters.
// A granted requester's 32-bit partial sum is handed to the engine; the raw
// engine sum is folded to a 16-bit complemented checksum and returned with a
// one-cycle done pulse. A transaction the engine never finishes is aborted
// after TIMEOUT_CYCLES wait cycles and reported with result_err.
//   AXI_ACLK, AXI_RESET   : clock, synchronous active-high reset
//   req, req_operand      : per-requester request level and 32-bit operand
//   gnt, done             : registered one-hot grant, one-cycle completion
//   result, result_err    : folded checksum / timeout flag, valid with done
//   eng_start, eng_operand: engine start pulse and operand
//   eng_done, eng_sum     : engine completion pulse and raw sum
//   clear_stats           : clears both statistics counters
//   grant_count           : completed transactions
//   timeout_count         : aborted transactions
module checksum_engine_arbiter
    import router_lookup_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                    AXI_ACLK,
    input  logic                    AXI_RESET,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*32-1:0]   req_operand,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      done,
    output logic [FoldW-1:0]        result,
    output logic                    result_err,
    output logic                    eng_start,
    output logic [31:0]             eng_operand,
    input  logic                    eng_done,
    input  logic [31:0]             eng_sum,
    input  logic                    clear_stats,
    output logic [31:0]             grant_count,
    output logic [31:0]             timeout_count
);

    localparam int unsigned IdxW   = $clog2(NUM_REQ);
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);

    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
    localparam logic [IdxW-1:0]   IdxLast   = IdxW'(NUM_REQ - 1);

    arb_state_e           state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IdxW-1:0]      gnt_idx_q, gnt_idx_d;
    logic [IdxW-1:0]      last_idx_q, last_idx_d;
    logic [TimerW-1:0]    timer_q, timer_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [FoldW-1:0]     result_q, result_d;
    logic                 err_q, err_d;
    logic                 start_q, start_d;
    logic [31:0]          operand_q, operand_d;
    logic [31:0]          grant_cnt_q, grant_cnt_d;
    logic [31:0]          timeout_cnt_q, timeout_cnt_d;

    logic [NUM_REQ-1:0]   pick;
    logic [IdxW-1:0]      pick_idx;
    logic [31:0]          pick_operand;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req      (req),
        .last_idx (last_idx_q),
        .pick     (pick)
    );

    // Encode the one-hot pick and select the matching operand slice.
    always_comb begin
        pick_idx     = '0;
        pick_operand = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_idx     = IdxW'(i);
                pick_operand = req_operand[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        last_idx_d = last_idx_q;
        timer_d    = timer_q;
        done_d     = '0;
        result_d   = result_q;
        err_d      = err_q;
        start_d    = 1'b0;
        operand_d  = operand_q;

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    gnt_d     = pick;
                    gnt_idx_d = pick_idx;
                    operand_d = pick_operand;
                    start_d   = 1'b1;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                // A completion on the last timer cycle beats the timeout.
                if (eng_done) begin
                    result_d = fold_sum(eng_sum);
                    err_d    = 1'b0;
                    done_d   = gnt_q;
                    state_d  = StDeliver;
                end else if (timer_q == TimerLast) begin
                    result_d = ErrResult;
                    err_d    = 1'b1;
                    done_d   = gnt_q;
                    state_d  = StDeliver;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StDeliver: begin
                gnt_d      = '0;
                last_idx_d = gnt_idx_q;
                state_d    = StIdle;
            end
            default: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Statistics; a clear in the same cycle as an increment leaves zero.
    always_comb begin
        grant_cnt_d   = grant_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        if (state_q == StDeliver) begin
            if (err_q) begin
                timeout_cnt_d = timeout_cnt_q + 32'd1;
            end else begin
                grant_cnt_d = grant_cnt_q + 32'd1;
            end
        end
        if (clear_stats) begin
            grant_cnt_d   = '0;
            timeout_cnt_d = '0;
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            state_q       <= StIdle;
            gnt_q         <= '0;
            gnt_idx_q     <= '0;
            last_idx_q    <= IdxLast;
            timer_q       <= '0;
            done_q        <= '0;
            result_q      <= '0;
            err_q         <= 1'b0;
            start_q       <= 1'b0;
            operand_q     <= '0;
            grant_cnt_q   <= '0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            gnt_idx_q     <= gnt_idx_d;
            last_idx_q    <= last_idx_d;
            timer_q       <= timer_d;
            done_q        <= done_d;
            result_q      <= result_d;
            err_q         <= err_d;
            start_q       <= start_d;
            operand_q     <= operand_d;
            grant_cnt_q   <= grant_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign gnt           = gnt_q;
    assign done          = done_q;
    assign result        = result_q;
    assign result_err    = err_q;
    assign eng_start     = start_q;
    assign eng_operand   = operand_q;
    assign grant_count   = grant_cnt_q;
    assign timeout_count = timeout_cnt_q;

endmodule

// File: doc/checksum_engine_arbiter.md
CHECKSUM_ENGINE_ARBITER -- requirements
Module: checksum_engine_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, WAIT-state cycles before abort (>=2).
REQ-003 SHALL have port AXI_ACLK  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port AXI_RESET  in  1  synchronous, active-high reset.
REQ-005 SHALL have port req  in  NUM_REQ  per-requester request level.
REQ-006 SHALL have port req_operand  in  NUM_REQ*32  per-requester 32-bit partial sum; slice i = bits [32i+31:32i].
REQ-007 SHALL have port gnt  out  NUM_REQ  one-hot grant, registered.
REQ-008 SHALL have port done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port result  out  16  folded, complemented checksum; valid when any done bit is high.
REQ-010 SHALL have port result_err  out  1  high with done when the transaction timed out.
REQ-011 SHALL have port eng_start  out  1  one-cycle start pulse to the shared engine.
REQ-012 SHALL have port eng_operand  out  32  operand of the granted requester, held from ISSUE through WAIT.
REQ-013 SHALL have port eng_done  in  1  engine completion pulse.
REQ-014 SHALL have port eng_sum  in  32  engine raw sum, sampled when eng_done is high.
REQ-015 SHALL have port clear_stats  in  1  counter clear pulse.
REQ-016 SHALL have port grant_count  out  32  completed transactions.
REQ-017 SHALL have port timeout_count  out  32  aborted transactions.

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DELIVER -> IDLE.
REQ-019 IDLE: if req is non-zero, SHALL select the first set req bit searching upward from (last_idx+1) mod NUM_REQ, register gnt, and enter ISSUE next cycle; otherwise it SHALL stay in IDLE.
REQ-020 ISSUE: SHALL assert eng_start for exactly one cycle, drive eng_operand from the granted slice, clear the timer, and enter WAIT.
REQ-021 WAIT: on eng_done, SHALL capture the folded result, clear result_err, and enter DELIVER; eng_done in any other state SHALL be ignored.
REQ-022 WAIT: when the timer reaches TIMEOUT_CYCLES-1 without eng_done, SHALL set result=16'hFFFF and result_err=1, and enter DELIVER; eng_done in that same cycle SHALL take priority over timeout.
REQ-023 DELIVER: SHALL pulse done[g] for one cycle, drop gnt in the following cycle, set last_idx=g, and return to IDLE.
REQ-024 Fold: s1 = sum[15:0] + sum[31:16] (17 bits); s2 = s1[15:0] + s1[16]; result = ~s2[15:0].
REQ-025 Minimum latency SHALL be: req seen in IDLE at cycle 0, gnt and eng_start at cycle 1, done at cycle 2 + (engine latency), counting eng_done arriving no earlier than cycle 2.
REQ-026 Deassertion of req after grant SHALL NOT abort the transaction; done SHALL still pulse.
REQ-027 A requester holding req SHALL be re-granted only after every other active requester has been served once (round-robin fairness).
REQ-028 grant_count SHALL increment in DELIVER when result_err=0; timeout_count SHALL increment in DELIVER when result_err=1; both SHALL wrap at 2^32.
REQ-029 clear_stats coinciding with an increment SHALL win, leaving the counter at 0.
REQ-030 gnt SHALL be at most one-hot at all times, and all-zero in IDLE.

Reset
REQ-031 AXI_RESET SHALL force IDLE, gnt=0, done=0, result=0, result_err=0, eng_start=0, eng_operand=0, counters=0, and last_idx=NUM_REQ-1 (so requester 0 is first after reset).
REQ-032 Reset asserted mid-transaction SHALL abandon it with no done pulse; a late eng_done SHALL then be ignored in IDLE.

Structure
REQ-033 State encodings, the fold width (16) and the error result constant 16'hFFFF SHALL live in shared package router_lookup_pkg.
REQ-034 The round-robin priority picker SHALL be a sub-module rr_pick (inputs: req, last_idx; output: one-hot pick).

Verification
REQ-035 Single: req=0001, operand=32'h0001_FFFF, eng_done with eng_sum=32'h0001_FFFF 3 cycles after eng_start -> done=0001, result=16'hFFFE, grant_count=1.
REQ-036 Contention: req=1111 held for 4 transactions -> grant order 0,1,2,3; each done one-hot; no overlapping gnt.
REQ-037 Timeout: eng_done never arrives, TIMEOUT_CYCLES=64 -> done after 64 WAIT cycles, result=16'hFFFF, result_err=1, timeout_count=1.
REQ-038 Race: eng_done on the final timeout cycle -> normal result, result_err=0, timeout_count unchanged.
REQ-039 Reset in WAIT, then eng_done -> no done pulse; after reset, req=0100 is granted as index 2.
REQ-040 clear_stats in the same cycle as DELIVER -> grant_count=0 on the next cycle.
